// File: rtl/dp_bus_master_if.sv
// dp_bus_master_if: rvsoc memory bus as seen by one initiator.
//   mem_valid  initiator -> responder  transaction request
//   mem_ready  responder -> initiator  1-cycle completion
//   mem_wstrb  initiator -> responder  4'b0000 read, 4'b1111 write
//   mem_addr   initiator -> responder  word-aligned byte address
//   mem_wdata  initiator -> responder  write data
//   mem_rdata  responder -> initiator  read data, valid with mem_valid & mem_ready
interface dp_bus_master_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_wstrb, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_wstrb, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/dp_bus_master.sv
// dp_bus_master: copy engine that reads COUNT words from a source region and
// writes each one to a destination (fixed register port or incrementing).
// Every word is a read, one idle cycle, a write, one idle cycle.
//
// Ports:
//   clk, reset   clock; asynchronous active-high reset
//   start        1-cycle command strobe, honoured only in IDLE
//   src_addr     source byte address (bits[1:0] ignored)
//   dst_addr     destination byte address (bits[1:0] ignored)
//   count        number of words to copy
//   dst_incr     1: destination advances by 4 per word; 0: fixed
//   busy         high while the copy is on the bus
//   done         1-cycle pulse at end of command
//   err          sticky timeout flag, cleared by the next accepted start
//   words_done   words fully written in the current/last command
//   mem          bus initiator (dp_bus_master_if.master)
//
// Optional feature: define DP_TIMEOUT_EN to abort a transaction whose
// mem_ready has not arrived after TIMEOUT_CYCLES cycles (sets err, ends the
// command with a done pulse). Without it the engine waits forever and err is 0.
module dp_bus_master #(
  parameter int unsigned CNT_W = 16
`ifdef DP_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            src_addr,
  input  logic [31:0]            dst_addr,
  input  logic [CNT_W-1:0]       count,
  input  logic                   dst_incr,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [CNT_W-1:0]       words_done,
  dp_bus_master_if.master        mem
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RGAP, S_WR, S_WGAP, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       src_q, src_d;
  logic [31:0]       dst_q, dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              incr_q, incr_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

`ifdef DP_TIMEOUT_EN
  localparam int unsigned WAIT_W =
    ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
`endif

  // Byte-offset bits of the command addresses are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      incr_q  <= 1'b0;
      words_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef DP_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      incr_q  <= incr_d;
      words_q <= words_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef DP_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic computes the next value of every registered output, so
  // each bus signal changes on the same edge as the state it belongs to.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    incr_d  = incr_q;
    words_d = words_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef DP_TIMEOUT_EN
    wait_d  = '0;
    err_d   = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = {src_addr[31:2], 2'b00};
          dst_d   = {dst_addr[31:2], 2'b00};
          cnt_d   = count;
          incr_d  = dst_incr;
          words_d = '0;
`ifdef DP_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          if (count != '0) begin
            state_d = S_RD;
            busy_d  = 1'b1;
            valid_d = 1'b1;
            wstrb_d = '0;
            addr_d  = {src_addr[31:2], 2'b00};
          end else begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end
        end
      end

      S_RD: begin
        if (mem.mem_ready) begin
          wdata_d = mem.mem_rdata;
          src_d   = src_q + 32'd4;
          valid_d = 1'b0;
          state_d = S_RGAP;
        end
      end

      S_RGAP: begin
        state_d = S_WR;
        valid_d = 1'b1;
        wstrb_d = '1;
        addr_d  = dst_q;
      end

      S_WR: begin
        if (mem.mem_ready) begin
          words_d = words_q + CNT_W'(1);
          if (incr_q) dst_d = dst_q + 32'd4;
          valid_d = 1'b0;
          wstrb_d = '0;
          state_d = S_WGAP;
        end
      end

      S_WGAP: begin
        if (words_q == cnt_q) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_RD;
          valid_d = 1'b1;
          wstrb_d = '0;
          addr_d  = src_q;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        wstrb_d = '0;
      end
    endcase

`ifdef DP_TIMEOUT_EN
    // Abort overrides the case above: the edge that completes the
    // TIMEOUT_CYCLES-th unanswered cycle drops mem_valid and finishes.
    if ((state_q == S_RD || state_q == S_WR) && !mem.mem_ready) begin
      if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_FIN;
        valid_d = 1'b0;
        wstrb_d = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
`endif
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign words_done    = words_q;
  assign mem.mem_valid = valid_q;
  assign mem.mem_wstrb = wstrb_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
`ifdef DP_TIMEOUT_EN
  assign err           = err_q;
`else
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_dp_bus_master.sv
module tb_dp_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] count = '0;
  logic        dst_incr = 1'b0;
  logic        busy, done, err;
  logic [15:0] words_done;

  dp_bus_master_if mem_if();

`ifdef DP_TIMEOUT_EN
  dp_bus_master #(.CNT_W(16), .TIMEOUT_CYCLES(8)) dut (
`else
  dp_bus_master #(.CNT_W(16)) dut (
`endif
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .count(count), .dst_incr(dst_incr), .busy(busy),
    .done(done), .err(err), .words_done(words_done), .mem(mem_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Responder / monitor state
  int          waits = 0;
  logic        spur = 1'b0;
  logic        hang = 1'b0;
  int          wcnt = 0;
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          gaps[$];
  int          low_run = 0;
  logic        in_cmd = 1'b0;
  int          done_cnt = 0;
  int          stab_err = 0;
  int          drop_err = 0;
  logic        busy_seen = 1'b0;
  logic        valid_seen = 1'b0;
  logic        p_valid = 1'b0, p_ready = 1'b0;
  logic [3:0]  p_wstrb = '0;
  logic [31:0] p_addr = '0, p_wdata = '0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] n, input logic inc);
    src_addr = s; dst_addr = d; count = n; dst_incr = inc; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_addr.delete(); wr_data.delete(); gaps.delete();
    stab_err = 0; drop_err = 0; busy_seen = 1'b0; valid_seen = 1'b0;
  endtask

  function automatic int gap_min();
    int m = 1000;
    foreach (gaps[i]) if (gaps[i] < m) m = gaps[i];
    return m;
  endfunction

  function automatic int gap_max();
    int m = 0;
    foreach (gaps[i]) if (gaps[i] > m) m = gaps[i];
    return m;
  endfunction

  // Responder and protocol monitor, evaluated on the falling edge.
  initial begin
    logic        nr;
    logic [31:0] nd;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (p_valid && !p_ready && !reset) begin
        if (!mem_if.mem_valid) drop_err++;
        else if (mem_if.mem_addr !== p_addr || mem_if.mem_wstrb !== p_wstrb ||
                 mem_if.mem_wdata !== p_wdata) stab_err++;
      end
      if (mem_if.mem_valid) begin
        if (in_cmd && low_run > 0) gaps.push_back(low_run);
        low_run = 0;
        in_cmd = 1'b1;
        valid_seen = 1'b1;
      end else begin
        low_run++;
      end
      if (busy) busy_seen = 1'b1;
      if (done) done_cnt++;
      if (done || reset) begin
        in_cmd = 1'b0;
        low_run = 0;
      end
      nr = 1'b0;
      nd = '0;
      if (mem_if.mem_valid && !reset) begin
        if (hang && mem_if.mem_wstrb == 4'h0 && rd_log.size() >= 1) begin
          wcnt++;
        end else if (wcnt >= waits) begin
          nr = 1'b1;
          wcnt = 0;
          if (mem_if.mem_wstrb == 4'h0) begin
            nd = data_of(mem_if.mem_addr);
            rd_log.push_back(mem_if.mem_addr);
          end else begin
            wr_addr.push_back(mem_if.mem_addr);
            wr_data.push_back(mem_if.mem_wdata);
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        nr = spur;
      end
      mem_if.mem_ready = nr;
      mem_if.mem_rdata = nd;
      p_valid = mem_if.mem_valid;
      p_ready = nr;
      p_addr  = mem_if.mem_addr;
      p_wstrb = mem_if.mem_wstrb;
      p_wdata = mem_if.mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   d0;
    int   hung;
    logic found;

    // Reset state
    tick(); tick();
    chk("rst_valid", mem_if.mem_valid, 0);
    chk("rst_wstrb", mem_if.mem_wstrb, 0);
    chk("rst_addr", mem_if.mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words", words_done, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    tick();

    // 1: RAM-to-RAM copy, zero-wait responder
    clear_logs(); d0 = done_cnt; waits = 0;
    start_cmd(32'h100, 32'h200, 16'd4, 1'b1);
    chk("copy_first_valid", mem_if.mem_valid, 1);
    chk("copy_first_addr", mem_if.mem_addr, 32'h100);
    chk("copy_first_busy", busy, 1);
    wait_done(60, cyc);
    // 4 words x 4 cycles after the start-sampling edge
    chk("copy_done_latency", cyc, 16);
    chk("copy_words", words_done, 4);
    chk("copy_busy_at_done", busy, 0);
    chk("copy_nwrites", wr_addr.size(), 4);
    chk("copy_nreads", rd_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("copy_wr_addr%0d", i), wr_addr[i], 32'h200 + 32'(4 * i));
      chk($sformatf("copy_wr_data%0d", i), wr_data[i], data_of(32'h100 + 32'(4 * i)));
    end
    chk("copy_gap_min", gap_min(), 1);
    chk("copy_gap_max", gap_max(), 1);
    chk("copy_stable", stab_err, 0);
    tick();
    chk("copy_done_pulse_width", done, 0);
    chk("copy_done_count", done_cnt - d0, 1);

    // 2: register stream, 2 wait states, stray ready while idle
    clear_logs(); d0 = done_cnt; waits = 2; spur = 1'b1;
    start_cmd(32'h300, 32'h0200100C, 16'd3, 1'b0);
    wait_done(100, cyc);
    chk("strm_done_latency", cyc, 24);
    chk("strm_words", words_done, 3);
    chk("strm_nwrites", wr_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("strm_wr_addr%0d", i), wr_addr[i], 32'h0200100C);
      chk($sformatf("strm_wr_data%0d", i), wr_data[i], data_of(32'h300 + 32'(4 * i)));
    end
    chk("strm_gap_min", gap_min(), 1);
    chk("strm_gap_max", gap_max(), 1);
    chk("strm_stable", stab_err, 0);
    chk("strm_no_drop", drop_err, 0);
    spur = 1'b0; waits = 0;
    tick();

    // 3: count = 0
    clear_logs(); d0 = done_cnt;
    start_cmd(32'h100, 32'h200, 16'd0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1) found = 1'b1;
      if (!found) tick();
    end
    chk("zero_done_in_time", found, 1);
    tick(); tick(); tick();
    chk("zero_done_count", done_cnt - d0, 1);
    chk("zero_no_valid", valid_seen, 0);
    chk("zero_no_busy", busy_seen, 0);
    chk("zero_words", words_done, 0);

    // 4: start while busy is ignored; next start after done runs (with wrap)
    clear_logs(); d0 = done_cnt;
    start_cmd(32'h400, 32'h500, 16'd2, 1'b1);
    tick(); tick();
    start_cmd(32'h900, 32'h980, 16'd7, 1'b0);
    wait_done(60, cyc);
    chk("busy_start_done_seen", (cyc > 0), 1);
    for (int i = 0; i < 6; i++) tick();
    chk("busy_start_words", words_done, 2);
    chk("busy_start_nwrites", wr_addr.size(), 2);
    chk("busy_start_wr1", wr_addr[1], 32'h504);
    chk("busy_start_rd1", rd_log[1], 32'h404);
    chk("busy_start_done_count", done_cnt - d0, 1);
    clear_logs();
    start_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFE, 16'd2, 1'b1);
    wait_done(60, cyc);
    chk("wrap_words", words_done, 2);
    chk("wrap_rd0", rd_log[0], 32'hFFFF_FFFC);
    chk("wrap_rd1", rd_log[1], 32'h0000_0000);
    chk("wrap_wr0", wr_addr[0], 32'hFFFF_FFFC);
    chk("wrap_wr1", wr_addr[1], 32'h0000_0000);
    chk("wrap_data0", wr_data[0], 32'hFFFC_0003);
    chk("wrap_data1", wr_data[1], 32'h0000_FFFF);
    chk("wrap_err", err, 0);
    tick();

    // 5: asynchronous reset in the middle of a write
    clear_logs(); waits = 3;
    start_cmd(32'h1000, 32'h2000, 16'd2, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (mem_if.mem_valid === 1'b1 && mem_if.mem_wstrb === 4'hF) found = 1'b1;
    end
    chk("rstmid_reached_wr", found, 1);
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    chk("rstmid_valid", mem_if.mem_valid, 0);
    chk("rstmid_wstrb", mem_if.mem_wstrb, 0);
    chk("rstmid_addr", mem_if.mem_addr, 0);
    chk("rstmid_wdata", mem_if.mem_wdata, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_words", words_done, 0);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("rstmid_no_done", done_cnt - d0, 0);
    clear_logs(); waits = 0;
    start_cmd(32'h1100, 32'h2100, 16'd1, 1'b1);
    wait_done(30, cyc);
    chk("rstmid_after_latency", cyc, 4);
    chk("rstmid_after_words", words_done, 1);
    chk("rstmid_after_wr", wr_addr[0], 32'h2100);
    chk("rstmid_after_data", wr_data[0], data_of(32'h1100));
    tick();

`ifdef DP_TIMEOUT_EN
    // 6: responder never answers the second read
    clear_logs(); hang = 1'b1; waits = 0; hung = 0;
    start_cmd(32'h3000, 32'h4000, 16'd3, 1'b1);
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (mem_if.mem_valid === 1'b1 && mem_if.mem_addr === 32'h3004) hung++;
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
    chk("tmo_done_seen", (cyc > 0), 1);
    chk("tmo_valid_cycles", hung, 8);
    chk("tmo_err", err, 1);
    chk("tmo_words", words_done, 1);
    chk("tmo_valid_low", mem_if.mem_valid, 0);
    hang = 1'b0;
    tick();
    chk("tmo_err_sticky", err, 1);
    start_cmd(32'h3100, 32'h4100, 16'd1, 1'b1);
    chk("tmo_err_cleared", err, 0);
    wait_done(30, cyc);
    chk("tmo_next_words", words_done, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
